// File: rtl/sipo_align_pkg.sv
// sipo_align_pkg: shared types and constants for the serial comma aligner.
package sipo_align_pkg;

  localparam int SYM_W = 10;

  // First seven bits of K28.5, bit 0 first on the wire.
  localparam logic [6:0] COMMA_NEG_7B = 7'b1111100;
  localparam logic [6:0] COMMA_POS_7B = 7'b0000011;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

endpackage

// File: rtl/sipo_comma_align_comma_detect.sv
// comma_detect: combinational match of a 7-bit window against both K28.5
// comma prefixes (either running disparity).
module comma_detect
  import sipo_align_pkg::*;
(
  input  logic [6:0] win_i,
  output logic       hit_o
);

  // Either disparity of the comma prefix counts as a hit.
  always_comb begin
    hit_o = (win_i == COMMA_NEG_7B) || (win_i == COMMA_POS_7B);
  end

endmodule

// File: rtl/sipo_comma_align.sv
// sipo_comma_align: LSB-first serial-to-parallel converter that finds K28.5
// commas, frames 10b symbols on the comma phase and reports lock.
// Build option: define SIPO_ALIGN_REALIGN_EN to let LOCKED fall back to HUNT
// after LOSS_CNT consecutive off-boundary commas; without it LOCKED is left
// only through rst or resync.
module sipo_comma_align
  import sipo_align_pkg::*;
#(
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             en,
  input  logic             resync,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic             sym_is_comma,
  output logic             locked
);

  localparam logic [2:0] LOCK_N    = 3'(LOCK_CNT);
  localparam logic [3:0] BCNT_LAST = 4'(SYM_W - 1);
`ifdef SIPO_ALIGN_REALIGN_EN
  localparam logic [2:0] LOSS_N    = 3'(LOSS_CNT);
`endif

  // Counters are 3 bits wide, so both thresholds must fit in 1..7.
  if (LOCK_CNT < 1 || LOCK_CNT > 7) begin : g_bad_lock_cnt
    $error("sipo_comma_align: LOCK_CNT must be 1..7");
  end
  if (LOSS_CNT < 1 || LOSS_CNT > 7) begin : g_bad_loss_cnt
    $error("sipo_comma_align: LOSS_CNT must be 1..7");
  end

  // Window bit 0 is always shifted out before it is looked at again, so only
  // bits 9..1 are kept; the 10-bit window is rebuilt with the incoming bit.
  logic [SYM_W-1:1] sr_q, sr_d;
  logic [SYM_W-1:0] nxt;
  logic [3:0]       bcnt_q, bcnt_d, bcnt_inc;
  logic [2:0]       ccnt_q, ccnt_d, ccnt_inc;
  align_state_e     state_q, state_d;
  logic             hit, bnd, emit, emit_cma;
  logic [SYM_W-1:0] sym_q;
  logic             vld_q, cma_q, lock_q;
`ifdef SIPO_ALIGN_REALIGN_EN
  logic [2:0]       lcnt_q, lcnt_d, lcnt_inc;
`endif

  // Candidate window including the bit presented this cycle.
  always_comb begin
    nxt      = {sin, sr_q};
    bnd      = (bcnt_q == BCNT_LAST);
    bcnt_inc = bnd ? 4'd0 : bcnt_q + 4'd1;
    ccnt_inc = ccnt_q + 3'd1;
`ifdef SIPO_ALIGN_REALIGN_EN
    lcnt_inc = lcnt_q + 3'd1;
`endif
  end

  comma_detect u_comma_detect (
    .win_i (nxt[6:0]),
    .hit_o (hit)
  );

  // Alignment FSM: next state, counters and symbol emission for this bit.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bcnt_d   = bcnt_q;
    ccnt_d   = ccnt_q;
    emit     = 1'b0;
    emit_cma = 1'b0;
`ifdef SIPO_ALIGN_REALIGN_EN
    lcnt_d   = lcnt_q;
`endif
    if (en) begin
      sr_d   = nxt[SYM_W-1:1];
      bcnt_d = bcnt_inc;
    end
    if (resync) begin
      // Overrides any comma event this cycle; the window still shifts.
      state_d = HUNT;
      bcnt_d  = 4'd0;
      ccnt_d  = 3'd0;
`ifdef SIPO_ALIGN_REALIGN_EN
      lcnt_d  = 3'd0;
`endif
    end else if (en) begin
      unique case (state_q)
        HUNT: begin
          if (hit) begin
            emit     = 1'b1;
            emit_cma = 1'b1;
            bcnt_d   = 4'd0;
            ccnt_d   = 3'd1;
            state_d  = (LOCK_N == 3'd1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (bnd) begin
            emit     = 1'b1;
            emit_cma = hit;
            if (hit) begin
              ccnt_d = ccnt_inc;
              if (ccnt_inc == LOCK_N) state_d = LOCKED;
            end
          end else if (hit) begin
            // Comma on a new phase: restart framing from it.
            emit     = 1'b1;
            emit_cma = 1'b1;
            bcnt_d   = 4'd0;
            ccnt_d   = 3'd1;
          end
        end
        LOCKED: begin
          if (bnd) begin
            emit     = 1'b1;
            emit_cma = hit;
`ifdef SIPO_ALIGN_REALIGN_EN
            if (hit) lcnt_d = 3'd0;
          end else if (hit) begin
            if (lcnt_inc == LOSS_N) begin
              state_d = HUNT;
              bcnt_d  = 4'd0;
              ccnt_d  = 3'd0;
              lcnt_d  = 3'd0;
            end else begin
              lcnt_d = lcnt_inc;
            end
`endif
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State, counters, window and registered symbol outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      sr_q    <= '0;
      bcnt_q  <= 4'd0;
      ccnt_q  <= 3'd0;
      sym_q   <= '0;
      vld_q   <= 1'b0;
      cma_q   <= 1'b0;
      lock_q  <= 1'b0;
`ifdef SIPO_ALIGN_REALIGN_EN
      lcnt_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      ccnt_q  <= ccnt_d;
      vld_q   <= emit;
      lock_q  <= (state_d == LOCKED);
      if (emit) begin
        sym_q <= nxt;
        cma_q <= emit_cma;
      end
`ifdef SIPO_ALIGN_REALIGN_EN
      lcnt_q  <= lcnt_d;
`endif
    end
  end

  assign sym_out      = sym_q;
  assign sym_valid    = vld_q;
  assign sym_is_comma = cma_q;
  assign locked       = lock_q;

endmodule

// File: tb/tb_sipo_comma_align.sv
// tb_sipo_comma_align: directed serial streams with a scoreboard of expected
// framed symbols; a negedge monitor compares every sym_valid against it.
module tb_sipo_comma_align;

  typedef struct packed {
    logic [9:0] sym;
    logic       cma;
    logic       lck;
  } exp_t;

  localparam logic [9:0] K_NEG = 10'h17C;
  localparam logic [9:0] K_POS = 10'h283;
  localparam logic [9:0] D_AA  = 10'h2AA;

  logic       clk = 1'b0;
  logic       rst, sin, en, resync;
  logic [9:0] sym_out;
  logic       sym_valid, sym_is_comma, locked;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  sipo_comma_align dut (
    .clk          (clk),
    .rst          (rst),
    .sin          (sin),
    .en           (en),
    .resync       (resync),
    .sym_out      (sym_out),
    .sym_valid    (sym_valid),
    .sym_is_comma (sym_is_comma),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [9:0] s, input logic c, input logic l);
    exp_t e;
    e.sym = s;
    e.cma = c;
    e.lck = l;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b, input logic rs);
    @(negedge clk);
    sin    = b;
    en     = 1'b1;
    resync = rs;
  endtask

  task automatic gap();
    @(negedge clk);
    sin    = 1'b0;
    en     = 1'b0;
    resync = 1'b0;
  endtask

  task automatic send_sym(input logic [9:0] s, input bit gaps);
    for (int i = 0; i < 10; i++) begin
      send_bit(s[i], 1'b0);
      if (gaps) gap();
    end
  endtask

  // Monitor: every emitted symbol must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst && sym_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sym: got=%0h want=none", sym_out);
      end else begin
        e = exp_q.pop_front();
        check("sym_out", 16'(sym_out), 16'(e.sym));
        check("sym_is_comma", 16'(sym_is_comma), 16'(e.cma));
        check("locked_at_sym", 16'(locked), 16'(e.lck));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sin = 1'b0; en = 1'b0; resync = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sym_out", 16'(sym_out), 16'h0);
    check("rst_sym_valid", 16'(sym_valid), 16'h0);
    check("rst_sym_is_comma", 16'(sym_is_comma), 16'h0);
    check("rst_locked", 16'(locked), 16'h0);
    rst = 1'b1;

    // Idle zeros then two RD- commas: first one found in HUNT, second locks.
    push(K_NEG, 1'b1, 1'b0);
    push(K_NEG, 1'b1, 1'b1);
    for (int i = 0; i < 13; i++) send_bit(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(K_NEG[i], 1'b0);
    check("no_early_valid", 16'(sym_valid), 16'h0);
    gap();
    check("valid_one_clk_after", 16'(sym_valid), 16'h1);
    gap();
    check("valid_one_pulse", 16'(sym_valid), 16'h0);
    check("not_locked_after_1st", 16'(locked), 16'h0);
    send_sym(K_NEG, 1'b0);
    gap();
    check("locked_after_2nd", 16'(locked), 16'h1);

    // Back to HUNT, then RD+ comma, data, RD+ comma.
    @(negedge clk); en = 1'b0; resync = 1'b1;
    gap();
    check("resync_unlocks", 16'(locked), 16'h0);
    push(K_POS, 1'b1, 1'b0);
    push(D_AA,  1'b0, 1'b0);
    push(K_POS, 1'b1, 1'b1);
    send_sym(K_POS, 1'b0);
    send_sym(D_AA, 1'b0);
    send_sym(K_POS, 1'b0);
    gap();

    // Locked with en toggling every bit: same symbols, stretched timing.
    push(D_AA,  1'b0, 1'b1);
    push(K_POS, 1'b1, 1'b1);
    send_sym(D_AA, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send_bit(K_POS[i], 1'b0);
      gap();
      if (i == 9) check("gap_valid_after_last", 16'(sym_valid), 16'h1);
    end
    gap();
    check("gap_valid_drops", 16'(sym_valid), 16'h0);

    // Resync on the cycle of a boundary comma: no emission, lock drops.
    for (int i = 0; i < 10; i++) send_bit(K_NEG[i], (i == 9) ? 1'b1 : 1'b0);
    gap();
    check("resync_no_valid", 16'(sym_valid), 16'h0);
    check("resync_locked_low", 16'(locked), 16'h0);

    // Relock, then shift the comma phase by three bits.
    push(K_NEG, 1'b1, 1'b0);
    push(K_NEG, 1'b1, 1'b1);
    send_sym(K_NEG, 1'b0);
    send_sym(K_NEG, 1'b0);
`ifdef SIPO_ALIGN_REALIGN_EN
    push(10'h3E0, 1'b0, 1'b1);
    push(10'h3E2, 1'b0, 1'b1);
    push(10'h3E2, 1'b0, 1'b1);
    push(10'h3E2, 1'b0, 1'b1);
    push(K_NEG,   1'b1, 1'b0);
    push(K_NEG,   1'b1, 1'b1);
`else
    push(10'h3E0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) push(10'h3E2, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    send_sym(K_NEG, 1'b0);
    send_sym(K_NEG, 1'b0);
    send_sym(K_NEG, 1'b0);
    gap();
    check("offphase_3_locked", 16'(locked), 16'h1);
    send_sym(K_NEG, 1'b0);
    gap();
`ifdef SIPO_ALIGN_REALIGN_EN
    check("offphase_4_locked", 16'(locked), 16'h0);
`else
    check("offphase_4_locked", 16'(locked), 16'h1);
`endif
    send_sym(K_NEG, 1'b0);
    send_sym(K_NEG, 1'b0);
    gap();
    check("offphase_end_locked", 16'(locked), 16'h1);

    // Reset five bits into a symbol, then lock again from a clean pair.
    for (int i = 0; i < 5; i++) send_bit(K_NEG[i], 1'b0);
    @(negedge clk); en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_sym_out", 16'(sym_out), 16'h0);
    check("midrst_sym_valid", 16'(sym_valid), 16'h0);
    check("midrst_sym_is_comma", 16'(sym_is_comma), 16'h0);
    check("midrst_locked", 16'(locked), 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(K_NEG, 1'b1, 1'b0);
    push(K_NEG, 1'b1, 1'b1);
    send_sym(K_NEG, 1'b0);
    send_sym(K_NEG, 1'b0);
    gap();
    check("postrst_locked", 16'(locked), 16'h1);
    repeat (3) gap();
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_comma_align.md
SIPO_COMMA_ALIGN -- requirements
Module: sipo_comma_align

Interface
REQ-001 SHALL provide parameter LOCK_CNT, default 2, meaning the number of consecutive boundary-aligned commas needed to enter LOCKED (range 1..7).
REQ-002 SHALL provide parameter LOSS_CNT, default 4, meaning the number of consecutive misaligned commas that drop lock (range 1..7, used only with REALIGN_EN).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sin  input  1  serial line bit; the first bit received is bit 0 of the symbol (LSB-first).
REQ-006 en  input  1  bit strobe; sin is sampled only when en=1.
REQ-007 resync  input  1  synchronous request to return to HUNT.
REQ-008 sym_out  output  10  aligned 10b symbol, registered.
REQ-009 sym_valid  output  1  one-cycle pulse; sym_out is valid while it is high.
REQ-010 sym_is_comma  output  1  qualifies sym_out as a comma symbol.
REQ-011 locked  output  1  high while state is LOCKED.

Function
REQ-012 Shift window SHALL update as nxt = {sin, sr[9:1]} and sr <= nxt, on every en=1 cycle only.
REQ-013 comma_hit SHALL be 1 when nxt[6:0] equals 7'b1111100 or 7'b0000011 (K28.5 RD-/RD+ first seven bits); it is evaluated only on en=1 cycles.
REQ-014 FSM states SHALL be HUNT, VERIFY and LOCKED.
REQ-015 Bit counter bcnt SHALL run 0..9 and advance on each en=1 cycle; a boundary is an en=1 cycle with bcnt==9; bcnt wraps to 0.
REQ-016 HUNT: on comma_hit, the FSM SHALL emit nxt as a symbol, set bcnt=0, set ccnt=1, and go to VERIFY; if LOCK_CNT==1 it goes directly to LOCKED.
REQ-017 VERIFY/LOCKED: at each boundary, the block SHALL emit nxt, with sym_is_comma=comma_hit.
REQ-018 VERIFY: a boundary comma SHALL increment ccnt; when ccnt reaches LOCK_CNT the FSM goes to LOCKED.
REQ-019 VERIFY: a boundary non-comma SHALL keep ccnt unchanged and keep the state in VERIFY.
REQ-020 VERIFY: an off-boundary comma SHALL re-phase the block (emit nxt, bcnt=0, ccnt=1, stay in VERIFY).
REQ-021 Emission latency SHALL be one clock: sym_out, sym_valid and sym_is_comma are registered in the cycle after the completing en cycle.
REQ-022 sym_valid SHALL be 0 in every other cycle; sym_out SHALL hold its last value.
REQ-023 en=0 SHALL freeze sr, bcnt, ccnt and the state.
REQ-024 resync=1 SHALL force HUNT and clear bcnt, ccnt and lcnt, with no emission that cycle; sr still shifts if en=1.
REQ-025 resync SHALL take priority over any comma event in the same cycle.
REQ-026 locked SHALL be registered and SHALL rise in the same cycle as the sym_valid of the locking comma.

Reset
REQ-027 While rst=0, sr, sym_out, bcnt, ccnt and lcnt SHALL be 0, sym_valid, sym_is_comma and locked SHALL be 0, and the state SHALL be HUNT.
REQ-028 Reset asserted mid-symbol SHALL discard the partial symbol; after release, the first accepted bit is treated as an unaligned stream bit.

Configuration
REQ-029 Macro SIPO_ALIGN_REALIGN_EN defined: in LOCKED, each off-boundary comma increments lcnt.
REQ-030 With SIPO_ALIGN_REALIGN_EN defined, a boundary comma clears lcnt.
REQ-031 With SIPO_ALIGN_REALIGN_EN defined, when lcnt reaches LOSS_CNT the FSM goes to HUNT (locked falls the next cycle) with no emission for that bit.
REQ-032 Macro not defined: LOCKED is left only via rst or resync; off-boundary commas are ignored and lcnt is not implemented.

Structure
REQ-033 Package sipo_align_pkg SHALL hold the state enum, the constants COMMA_NEG_7B=7'b1111100 and COMMA_POS_7B=7'b0000011, and the symbol width constant SYM_W=10.
REQ-034 Sub-module comma_detect SHALL be a combinational 7-bit matcher that is instantiated once.

Verification
REQ-035 Idle-zero stream, then 0x17C, 0x17C LSB-first -> first sym_valid with sym_out=0x17C and sym_is_comma=1 one clock after bit 10; locked=1 with the second comma.
REQ-036 Stream 0x283 (RD+ K28.5), then data 0x2AA, then 0x283 -> sym_out sequence 0x283, 0x2AA, 0x283; locked after the second comma; data sym_is_comma=0.
REQ-037 Locked, en toggled 1-0-1 per bit -> identical symbols, and sym_valid timing shifts with the en gaps only.
REQ-038 Locked, 4 commas injected 3 bits off-phase -> with SIPO_ALIGN_REALIGN_EN: locked falls after the 4th, then relocks on the new phase; without it: locked stays 1.
REQ-039 resync pulse while locked, coincident with a boundary comma -> no sym_valid that cycle, locked=0 next cycle, state HUNT.
REQ-040 rst asserted after 5 bits of a symbol -> all outputs 0 immediately; a clean comma pair after release achieves lock normally.
